dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin shared data memory: NPORTS data ports, one word-addressed byte-enable RAM, LATENCY-cycle responses.
// Optional macro DMEM_OOR_ERR_EN: addresses with bits set above the index field are flagged and suppressed.
module dmem_arbiter #(
  parameter int NPORTS  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NPORTS-1:0]            req_valid,
  output logic [NPORTS-1:0]            req_ready,
  input  logic [NPORTS-1:0]            req_write,
  input  logic [NPORTS*ADDR_W-1:0]     req_addr,
  input  logic [NPORTS*DATA_W-1:0]     req_wdata,
  input  logic [NPORTS*DATA_W/8-1:0]   req_be,
  output logic [NPORTS-1:0]            resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_oor;
  logic              unused_addr;
  logic [DATA_W-1:0] rd_dat;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NPORTS-1:0] pipe_vld [LATENCY];
  logic [DATA_W-1:0] pipe_dat [LATENCY];
  logic              pipe_err [LATENCY];

  // Ports above the last grant are searched first, then the wrap-around up to and including it.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = rr_ptr;
    req_ready = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (!gnt_any && req_valid[i] && (PTR_W'(i) > rr_ptr)) begin
        gnt_any      = 1'b1;
        gnt_idx      = PTR_W'(i);
        req_ready[i] = 1'b1;
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (!gnt_any && req_valid[i] && (PTR_W'(i) <= rr_ptr)) begin
        gnt_any      = 1'b1;
        gnt_idx      = PTR_W'(i);
        req_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (req_ready[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_be    = req_be[i*BE_W +: BE_W];
      end
    end
  end

  assign sel_idx = sel_addr[IDX_W+1:2];

`ifdef DMEM_OOR_ERR_EN
  localparam logic [DATA_W-1:0] OOR_DATA = DATA_W'(32'hDEADBEEF);
  assign sel_oor     = |sel_addr[ADDR_W-1:IDX_W+2];
  assign unused_addr = ^sel_addr[1:0];
`else
  assign sel_oor     = 1'b0;
  assign unused_addr = ^{sel_addr[ADDR_W-1:IDX_W+2], sel_addr[1:0]};
`endif

  // Reads sample the array before this edge's write; only one grant per cycle so no conflict.
  always_comb begin
    rd_dat = '0;
    if (gnt_any && !sel_write) rd_dat = mem[sel_idx];
`ifdef DMEM_OOR_ERR_EN
    if (gnt_any && !sel_write && sel_oor) rd_dat = OOR_DATA;
`endif
  end

  always_ff @(posedge clk) begin
    if (gnt_any && sel_write && !sel_oor) begin
      for (int b = 0; b < BE_W; b++) begin
        if (sel_be[b]) mem[sel_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= PTR_W'(NPORTS - 1);
      for (int s = 0; s < LATENCY; s++) begin
        pipe_vld[s] <= '0;
        pipe_dat[s] <= '0;
        pipe_err[s] <= 1'b0;
      end
    end else begin
      if (gnt_any) rr_ptr <= gnt_idx;
      pipe_vld[0] <= req_ready;
      pipe_dat[0] <= rd_dat;
      pipe_err[0] <= gnt_any & sel_oor;
      for (int s = 1; s < LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_dat[s] <= pipe_dat[s-1];
        pipe_err[s] <= pipe_err[s-1];
      end
    end
  end

  assign resp_valid = pipe_vld[LATENCY-1];
  assign resp_rdata = pipe_dat[LATENCY-1];
  assign resp_err   = pipe_err[LATENCY-1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two ports, LATENCY 3, both DMEM_OOR_ERR_EN builds.
module tb_dmem_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_write, resp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_be;
  logic [31:0] resp_rdata;
  logic        resp_err;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  dmem_arbiter #(.NPORTS(2), .DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single request on port p; returns the response seen and its latency from the grant cycle.
  task automatic access(input logic p, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [1:0] rv, output logic [31:0] rd,
                        output logic er, output int lat);
    int g;
    g = -1; lat = -1; rv = '0; rd = '0; er = 1'b0;
    @(negedge clk);
    req_valid[p] = 1'b1;
    req_write[p] = wr;
    req_addr[{p, 5'd0} +: 32]  = a;
    req_wdata[{p, 5'd0} +: 32] = d;
    req_be[{p, 2'd0} +: 4]     = b;
    for (int i = 0; i < 20 && g < 0; i++) begin
      #1;
      if (req_ready[p]) g = cyc;
      else @(negedge clk);
    end
    @(negedge clk);
    req_valid[p] = 1'b0;
    if (g < 0) return;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      #1;
      if (resp_valid != 2'b00) begin
        lat = cyc - g; rv = resp_valid; rd = resp_rdata; er = resp_err;
      end else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(negedge clk);
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid: got %b want 00", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
    reset = 1'b1;
    #1 req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_priority: got %b want 01", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_basic_rw;
    logic [1:0] rv; logic [31:0] rd; logic er; int lat;
    access(1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF, rv, rd, er, lat);
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL wr_resp_valid: got %b want 01", rv); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_resp_rdata: got %h want 0", rd); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
    access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rv, rd, er, lat);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rd_data: got %h want 12345678", rd); end
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL rd_resp_valid: got %b want 01", rv); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
  endtask

  task automatic test_byte_enable;
    logic [1:0] rv; logic [31:0] rd; logic er; int lat;
    access(1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, rv, rd, er, lat);
    checks++; if (rv !== 2'b10) begin errors++; $display("FAIL be_full_ack: got %b want 10", rv); end
    access(1'b1, 1'b1, 32'h20, 32'h00000011, 4'b0001, rv, rd, er, lat);
    checks++; if (rv !== 2'b10) begin errors++; $display("FAIL be_part_ack: got %b want 10", rv); end
    access(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rv, rd, er, lat);
    checks++; if (rv !== 2'b10) begin errors++; $display("FAIL be_none_ack: got %b want 10", rv); end
    access(1'b1, 1'b0, 32'h23, 32'h0, 4'h0, rv, rd, er, lat);
    checks++; if (rd !== 32'hAABBCC11) begin errors++; $display("FAIL be_merge: got %h want aabbcc11", rd); end
    checks++; if (rv !== 2'b10) begin errors++; $display("FAIL be_rd_valid: got %b want 10", rv); end
  endtask

  task automatic test_alternation;
    logic [1:0]  g [9];
    logic [1:0]  r [9];
    logic [31:0] dd [9];
    logic [1:0]  exp_g [9];
    logic [1:0]  exp_r [9];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    exp_r = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    @(negedge clk);
    req_write = 2'b00; req_addr = {32'h20, 32'h10}; req_valid = 2'b11;
    for (int s = 0; s < 9; s++) begin
      if (s == 6) req_valid = 2'b00;
      #1; g[s] = req_ready; r[s] = resp_valid; dd[s] = resp_rdata;
      @(negedge clk);
    end
    for (int s = 0; s < 9; s++) begin
      checks++; if (g[s] !== exp_g[s]) begin errors++; $display("FAIL alt_grant[%0d]: got %b want %b", s, g[s], exp_g[s]); end
      checks++; if (r[s] !== exp_r[s]) begin errors++; $display("FAIL alt_resp[%0d]: got %b want %b", s, r[s], exp_r[s]); end
      if (exp_r[s] == 2'b01) begin
        checks++; if (dd[s] !== 32'h12345678) begin errors++; $display("FAIL alt_data0[%0d]: got %h want 12345678", s, dd[s]); end
      end else if (exp_r[s] == 2'b10) begin
        checks++; if (dd[s] !== 32'hAABBCC11) begin errors++; $display("FAIL alt_data1[%0d]: got %h want aabbcc11", s, dd[s]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] rv; logic [31:0] rd; logic er; int lat;
    logic [1:0]  g [7];
    logic [1:0]  r [7];
    logic [31:0] dd [7];
    logic [1:0]  exp_r [7];
    logic [31:0] exp_d [7];
    exp_r = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    exp_d = '{32'h0, 32'h0, 32'h0, 32'h11110000, 32'h22220004, 32'h33330008, 32'h0};
    access(1'b0, 1'b1, 32'h0, 32'h11110000, 4'hF, rv, rd, er, lat);
    access(1'b0, 1'b1, 32'h4, 32'h22220004, 4'hF, rv, rd, er, lat);
    access(1'b0, 1'b1, 32'h8, 32'h33330008, 4'hF, rv, rd, er, lat);
    @(negedge clk);
    req_write[0] = 1'b0; req_valid[0] = 1'b1;
    for (int s = 0; s < 7; s++) begin
      if (s < 3) req_addr[31:0] = 32'(4 * s);
      else req_valid[0] = 1'b0;
      #1; g[s] = req_ready; r[s] = resp_valid; dd[s] = resp_rdata;
      @(negedge clk);
    end
    for (int s = 0; s < 3; s++) begin
      checks++; if (g[s] !== 2'b01) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want 01", s, g[s]); end
    end
    for (int s = 0; s < 7; s++) begin
      checks++; if (r[s] !== exp_r[s]) begin errors++; $display("FAIL b2b_resp[%0d]: got %b want %b", s, r[s], exp_r[s]); end
      if (exp_r[s] != 2'b00) begin
        checks++; if (dd[s] !== exp_d[s]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", s, dd[s], exp_d[s]); end
      end
    end
  endtask

  task automatic test_reset_inflight;
    logic [1:0] rv; logic [31:0] rd; logic er; int lat;
    int bad;
    bad = 0;
    @(negedge clk);
    req_write[0] = 1'b0; req_addr[31:0] = 32'h0; req_valid[0] = 1'b1;
    #1; checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL inflight_g0: got %b want 01", req_ready); end
    @(negedge clk);
    req_addr[31:0] = 32'h4;
    #1; checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL inflight_g1: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0; reset = 1'b0;
    for (int s = 0; s < 10; s++) begin
      if (s == 2) reset = 1'b1;
      #1; if (resp_valid !== 2'b00) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL inflight_dropped: got %0d responses want 0", bad); end
    access(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, rv, rd, er, lat);
    checks++; if (rd !== 32'h22220004) begin errors++; $display("FAIL inflight_kept: got %h want 22220004", rd); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL inflight_lat: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_oor;
    logic [1:0] rv; logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_rd, exp_alias;
    logic        exp_er;
`ifdef DMEM_OOR_ERR_EN
    exp_rd = 32'hDEADBEEF; exp_er = 1'b1; exp_alias = 32'h22220004;
`else
    exp_rd = 32'h11110000; exp_er = 1'b0; exp_alias = 32'h00000055;
`endif
    access(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, rv, rd, er, lat);
    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL oor_rd_data: got %h want %h", rd, exp_rd); end
    checks++; if (er !== exp_er) begin errors++; $display("FAIL oor_rd_err: got %b want %b", er, exp_er); end
    access(1'b1, 1'b1, 32'h104, 32'h00000055, 4'hF, rv, rd, er, lat);
    checks++; if (er !== exp_er) begin errors++; $display("FAIL oor_wr_err: got %b want %b", er, exp_er); end
    checks++; if (rv !== 2'b10) begin errors++; $display("FAIL oor_wr_ack: got %b want 10", rv); end
    access(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, rv, rd, er, lat);
    checks++; if (rd !== exp_alias) begin errors++; $display("FAIL oor_wr_effect: got %h want %h", rd, exp_alias); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL inrange_err: got %b want 0", er); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_byte_enable();
    test_alternation();
    test_back_to_back();
    test_reset_inflight();
    test_oor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
